// File: rtl/regbank_pkg.sv
// Shared types, default sizes and helpers for the register-bank arbiter.
package regbank_pkg;

  // Access sequencer states
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    GRANT  = 3'd1,
    ACCESS = 3'd2,
    DONE   = 3'd3,
    CLEAR  = 3'd4
  } state_t;

  localparam int DEF_N_REQ = 4;
  localparam int DEF_DEPTH = 8;
  localparam int DEF_WIDTH = 8;
  localparam int DEF_AW    = 3;

  // Ceiling log2, usable in parameter and port-width expressions
  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/regbank_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request bit strictly after
// ptr, wrapping modulo N_REQ (ptr itself is examined last).
module rr_pick
  import regbank_pkg::*;
#(
  parameter int N_REQ = DEF_N_REQ,
  parameter int IW    = clog2(DEF_N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IW-1:0]    ptr,
  output logic             found,
  output logic [IW-1:0]    winner
);

  logic [IW:0] cand_s;

  // Scan candidates farthest-first so the nearest one after ptr wins
  always_comb begin
    found  = 1'b0;
    winner = {IW{1'b0}};
    cand_s = {(IW+1){1'b0}};
    for (int k = N_REQ; k >= 1; k--) begin
      cand_s = {1'b0, ptr} + (IW+1)'(k);
      if (cand_s >= (IW+1)'(N_REQ)) begin
        cand_s = cand_s - (IW+1)'(N_REQ);
      end else begin
        cand_s = cand_s;
      end
      if (req[cand_s[IW-1:0]]) begin
        found  = 1'b1;
        winner = cand_s[IW-1:0];
      end else begin
        found  = found;
        winner = winner;
      end
    end
  end

endmodule

// File: rtl/regbank_arbiter.sv
// Round-robin shared access to a small flop-based register bank.
// Each command runs IDLE -> GRANT -> ACCESS -> DONE; a clear request
// sweeps zeros through the bank one word per cycle in CLEAR.
module regbank_arbiter
  import regbank_pkg::*;
#(
  parameter int N_REQ = DEF_N_REQ,
  parameter int DEPTH = DEF_DEPTH,
  parameter int WIDTH = DEF_WIDTH,
  parameter int AW    = DEF_AW
) (
  input  logic                      clk,
  input  logic                      Re,
  input  logic [N_REQ-1:0]          req,
  input  logic [N_REQ-1:0]          we,
  input  logic [N_REQ*AW-1:0]       addr,
  input  logic [N_REQ*WIDTH-1:0]    wdata,
  input  logic                      clr,
  output logic [N_REQ-1:0]          gnt,
  output logic                      ack,
  output logic [clog2(N_REQ)-1:0]   ack_id,
  output logic                      rvalid,
  output logic [WIDTH-1:0]          rdata,
  output logic                      busy
);

  localparam int IW = clog2(N_REQ);

  state_t            state_r;
  logic [IW-1:0]     ptr_r;
  logic              cmd_we_r;
  logic [AW-1:0]     cmd_addr_r;
  logic [WIDTH-1:0]  cmd_wdata_r;
  logic [AW-1:0]     clr_cnt_r;
  logic [WIDTH-1:0]  bank_r [DEPTH];

  logic              found_s;
  logic [IW-1:0]     pick_s;
  logic [N_REQ-1:0]  onehot_s;
  logic              addr_ok_s;
  logic [WIDTH-1:0]  rd_word_s;

  rr_pick #(
    .N_REQ (N_REQ),
    .IW    (IW)
  ) u_pick (
    .req    (req),
    .ptr    (ptr_r),
    .found  (found_s),
    .winner (pick_s)
  );

  // Winner one-hot and bounds-checked read of the latched address
  always_comb begin
    onehot_s  = {{(N_REQ-1){1'b0}}, 1'b1} << pick_s;
    addr_ok_s = (int'(cmd_addr_r) < DEPTH);
    if (addr_ok_s) begin
      rd_word_s = bank_r[cmd_addr_r];
    end else begin
      rd_word_s = {WIDTH{1'b0}};
    end
  end

  // Access sequencer, command latch, bank storage and registered outputs
  always_ff @(posedge clk or negedge Re) begin
    if (!Re) begin
      state_r     <= IDLE;
      ptr_r       <= IW'(N_REQ-1);
      cmd_we_r    <= 1'b0;
      cmd_addr_r  <= {AW{1'b0}};
      cmd_wdata_r <= {WIDTH{1'b0}};
      clr_cnt_r   <= {AW{1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        bank_r[i] <= {WIDTH{1'b0}};
      end
      gnt    <= {N_REQ{1'b0}};
      ack    <= 1'b0;
      ack_id <= {IW{1'b0}};
      rvalid <= 1'b0;
      rdata  <= {WIDTH{1'b0}};
      busy   <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          gnt    <= {N_REQ{1'b0}};
          ack    <= 1'b0;
          rvalid <= 1'b0;
          if (clr) begin
            clr_cnt_r <= {AW{1'b0}};
            busy      <= 1'b1;
            state_r   <= CLEAR;
          end else if (found_s) begin
            // Only the latched copy is used from here on
            cmd_we_r    <= we[pick_s];
            cmd_addr_r  <= addr[pick_s*AW +: AW];
            cmd_wdata_r <= wdata[pick_s*WIDTH +: WIDTH];
            ptr_r       <= pick_s;
            gnt         <= onehot_s;
            busy        <= 1'b1;
            state_r     <= GRANT;
          end else begin
            busy    <= 1'b0;
            state_r <= IDLE;
          end
        end
        GRANT: begin
          gnt     <= {N_REQ{1'b0}};
          state_r <= ACCESS;
        end
        ACCESS: begin
          if (cmd_we_r) begin
            // Out-of-range writes are dropped
            if (addr_ok_s) begin
              bank_r[cmd_addr_r] <= cmd_wdata_r;
            end
            rvalid <= 1'b0;
          end else begin
            rdata  <= rd_word_s;
            rvalid <= 1'b1;
          end
          ack     <= 1'b1;
          ack_id  <= ptr_r;
          state_r <= DONE;
        end
        DONE: begin
          ack     <= 1'b0;
          rvalid  <= 1'b0;
          busy    <= 1'b0;
          state_r <= IDLE;
        end
        CLEAR: begin
          bank_r[clr_cnt_r] <= {WIDTH{1'b0}};
          if (clr_cnt_r == AW'(DEPTH-1)) begin
            clr_cnt_r <= {AW{1'b0}};
            busy      <= 1'b0;
            state_r   <= IDLE;
          end else begin
            clr_cnt_r <= clr_cnt_r + {{(AW-1){1'b0}}, 1'b1};
          end
        end
        default: begin
          gnt     <= {N_REQ{1'b0}};
          ack     <= 1'b0;
          rvalid  <= 1'b0;
          busy    <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule
